// File: rtl/chroni_pixel_expander.sv
// chroni_pixel_expander
//   Write-side front end of the chroni line buffer RAM (sys_clk domain).
//   Takes one bitmap byte per request plus on/off colours and a bit count,
//   and serialises it MSB first into one colour-indexed pixel write per
//   clock at consecutive (wrapping) line buffer addresses. A bit count of
//   zero performs a single direct-colour write of wr_data.
//
// Ports
//   sys_clk, reset_n        clock, asynchronous active-low reset
//   wr_en                   request strobe (ignored while wr_busy)
//   wr_addr                 first pixel address of the request
//   wr_data                 bitmap byte, or direct colour when bits==0
//   wr_bitmap_on/off        colours for 1 / 0 bitmap bits
//   wr_bitmap_bits          0 = direct, 1..8 = bitmap, 9..15 as 8
//   wr_busy                 request in progress
//   ram_addr/ram_data/ram_we  registered line buffer RAM write port
//
// Build option
//   CHRONI_PIXEL_EXPANDER_TRANSPARENT_EN: bitmap 0 bits suppress ram_we
//   (address still advances, wr_bitmap_off unused).
module chroni_pixel_expander #(
  parameter int ADDR_W    = 11,
  parameter int COLOR_W   = 8,
  parameter int BUF_DEPTH = 1280
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [7:0]         wr_data,
  input  logic [COLOR_W-1:0] wr_bitmap_on,
  input  logic [COLOR_W-1:0] wr_bitmap_off,
  input  logic [3:0]         wr_bitmap_bits,
  output logic               wr_busy,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [COLOR_W-1:0] ram_data,
  output logic               ram_we
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [7:0]           shift_q, shift_d;
  logic [3:0]           count_q, count_d;
  logic                 direct_q, direct_d;
  logic [COLOR_W-1:0]   on_q, on_d;
`ifndef CHRONI_PIXEL_EXPANDER_TRANSPARENT_EN
  logic [COLOR_W-1:0]   off_q, off_d;
`endif
  logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
  logic [COLOR_W-1:0]   ram_data_q, ram_data_d;
  logic                 ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]    addr_next;

  // Direct colour reuses the shift register, which holds wr_data unshifted.
  always_comb begin
    addr_next = (addr_q == ADDR_W'(BUF_DEPTH - 1)) ? '0 : addr_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    count_d    = count_q;
    direct_d   = direct_q;
    on_d       = on_q;
`ifndef CHRONI_PIXEL_EXPANDER_TRANSPARENT_EN
    off_d      = off_q;
`endif
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          addr_d   = wr_addr;
          shift_d  = wr_data;
          on_d     = wr_bitmap_on;
`ifndef CHRONI_PIXEL_EXPANDER_TRANSPARENT_EN
          off_d    = wr_bitmap_off;
`endif
          direct_d = (wr_bitmap_bits == 4'd0);
          if (wr_bitmap_bits == 4'd0)
            count_d = 4'd1;
          else if (wr_bitmap_bits > 4'd8)
            count_d = 4'd8;
          else
            count_d = wr_bitmap_bits;
          state_d  = EXPAND;
        end
      end
      EXPAND: begin
        ram_addr_d = addr_q;
        addr_d     = addr_next;
        if (direct_q) begin
          ram_data_d = COLOR_W'(shift_q);
          ram_we_d   = 1'b1;
        end else begin
`ifdef CHRONI_PIXEL_EXPANDER_TRANSPARENT_EN
          ram_data_d = on_q;
          ram_we_d   = shift_q[7];
`else
          ram_data_d = shift_q[7] ? on_q : off_q;
          ram_we_d   = 1'b1;
`endif
          shift_d    = {shift_q[6:0], 1'b0};
        end
        count_d = count_q - 1'b1;
        if (count_q == 4'd1)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      shift_q    <= '0;
      count_q    <= '0;
      direct_q   <= 1'b0;
      on_q       <= '0;
`ifndef CHRONI_PIXEL_EXPANDER_TRANSPARENT_EN
      off_q      <= '0;
`endif
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      direct_q   <= direct_d;
      on_q       <= on_d;
`ifndef CHRONI_PIXEL_EXPANDER_TRANSPARENT_EN
      off_q      <= off_d;
`endif
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
    end
  end

  assign wr_busy  = (state_q == EXPAND);
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_we   = ram_we_q;

endmodule

// File: tb/tb_chroni_pixel_expander.sv
// Directed, table-driven bench for chroni_pixel_expander with hand-computed
// pixel sequences, plus sequences for ignored requests, wr_en held high,
// back-to-back acceptance and reset during an expansion.
module tb_chroni_pixel_expander;

`ifdef CHRONI_PIXEL_EXPANDER_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic        sys_clk;
  logic        reset_n;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  wr_bitmap_on;
  logic [7:0]  wr_bitmap_off;
  logic [3:0]  wr_bitmap_bits;
  logic        wr_busy;
  logic [10:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;

  int errors = 0;
  int checks = 0;

  chroni_pixel_expander #(.ADDR_W(11), .COLOR_W(8), .BUF_DEPTH(1280)) dut (
    .sys_clk        (sys_clk),
    .reset_n        (reset_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_bitmap_on   (wr_bitmap_on),
    .wr_bitmap_off  (wr_bitmap_off),
    .wr_bitmap_bits (wr_bitmap_bits),
    .wr_busy        (wr_busy),
    .ram_addr       (ram_addr),
    .ram_data       (ram_data),
    .ram_we         (ram_we)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [10:0]        addr;
    logic [7:0]         data;
    logic [7:0]         on;
    logic [7:0]         off;
    logic [3:0]         bits;
    logic [3:0]         n;     // expected number of pixels
    logic [7:0]         mask;  // expected ram_we per pixel in transparent build
    logic [0:7][10:0]   ea;
    logic [0:7][7:0]    ed;
  } vec_t;

  localparam int N_VEC = 8;
  vec_t vecs [N_VEC];

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic req(input logic [10:0] a, input logic [7:0] d, input logic [7:0] on,
                     input logic [7:0] off, input logic [3:0] b);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    wr_bitmap_on = on; wr_bitmap_off = off; wr_bitmap_bits = b;
  endtask

  // Check one emitted pixel; in the transparent build a cleared mask bit
  // means no write (data not checked), address still advances.
  task automatic pix(input string name, input logic [10:0] ea, input logic [7:0] ed,
                     input logic mbit, input logic busy);
    logic we_exp;
    we_exp = TRANSP ? mbit : 1'b1;
    chk({name, " ram_we"}, ram_we, we_exp);
    chk({name, " ram_addr"}, ram_addr, ea);
    if (we_exp) chk({name, " ram_data"}, ram_data, ed);
    chk({name, " wr_busy"}, wr_busy, busy);
  endtask

  initial begin
    vecs[0] = '{addr:11'd640, data:8'hA5, on:8'h0F, off:8'h00, bits:4'd8, n:4'd8, mask:8'hA5,
                ea:{11'd640,11'd641,11'd642,11'd643,11'd644,11'd645,11'd646,11'd647},
                ed:{8'h0F,8'h00,8'h0F,8'h00,8'h00,8'h0F,8'h00,8'h0F}};
    vecs[1] = '{addr:11'd5, data:8'h3C, on:8'h77, off:8'h88, bits:4'd0, n:4'd1, mask:8'h80,
                ea:{11'd5,77'd0}, ed:{8'h3C,56'd0}};
    vecs[2] = '{addr:11'd1278, data:8'hFF, on:8'h11, off:8'h22, bits:4'd4, n:4'd4, mask:8'hF0,
                ea:{11'd1278,11'd1279,11'd0,11'd1,44'd0},
                ed:{8'h11,8'h11,8'h11,8'h11,32'd0}};
    vecs[3] = '{addr:11'd100, data:8'h3C, on:8'hAA, off:8'h55, bits:4'd12, n:4'd8, mask:8'h3C,
                ea:{11'd100,11'd101,11'd102,11'd103,11'd104,11'd105,11'd106,11'd107},
                ed:{8'h55,8'h55,8'hAA,8'hAA,8'hAA,8'hAA,8'h55,8'h55}};
    vecs[4] = '{addr:11'd1279, data:8'h40, on:8'h01, off:8'h02, bits:4'd3, n:4'd3, mask:8'h40,
                ea:{11'd1279,11'd0,11'd1,55'd0}, ed:{8'h02,8'h01,8'h02,40'd0}};
    vecs[5] = '{addr:11'd10, data:8'h0F, on:8'h33, off:8'h33, bits:4'd8, n:4'd8, mask:8'h0F,
                ea:{11'd10,11'd11,11'd12,11'd13,11'd14,11'd15,11'd16,11'd17},
                ed:{8'h33,8'h33,8'h33,8'h33,8'h33,8'h33,8'h33,8'h33}};
    vecs[6] = '{addr:11'd1279, data:8'h80, on:8'hC3, off:8'h3C, bits:4'd1, n:4'd1, mask:8'h80,
                ea:{11'd1279,77'd0}, ed:{8'hC3,56'd0}};
    vecs[7] = '{addr:11'd1276, data:8'h81, on:8'h01, off:8'h00, bits:4'd8, n:4'd8, mask:8'h81,
                ea:{11'd1276,11'd1277,11'd1278,11'd1279,11'd0,11'd1,11'd2,11'd3},
                ed:{8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h01}};

    // Reset held low while inputs toggle.
    reset_n = 1'b1;
    req(11'd0, 8'h00, 8'h00, 8'h00, 4'd0);
    wr_en = 1'b0;
    #3 reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(11'(i * 300), 8'(i * 37 + 1), 8'hFF, 8'h5A, 4'(i * 3));
      step();
      chk("reset wr_busy", wr_busy, 1'b0);
      chk("reset ram_we", ram_we, 1'b0);
      chk("reset ram_addr", ram_addr, 11'd0);
      chk("reset ram_data", ram_data, 8'h00);
    end
    wr_en = 1'b0;
    #2 reset_n = 1'b1;
    step();
    chk("post-reset wr_busy", wr_busy, 1'b0);

    // Table-driven requests.
    for (int v = 0; v < N_VEC; v++) begin
      req(vecs[v].addr, vecs[v].data, vecs[v].on, vecs[v].off, vecs[v].bits);
      step();
      chk($sformatf("vec%0d accept busy", v), wr_busy, 1'b1);
      chk($sformatf("vec%0d accept we", v), ram_we, 1'b0);
      wr_en = 1'b0;
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        step();
        pix($sformatf("vec%0d px%0d", v, i), vecs[v].ea[i], vecs[v].ed[i],
            vecs[v].mask[7 - i], i < int'(vecs[v].n) - 1);
      end
      step();
      chk($sformatf("vec%0d tail we", v), ram_we, 1'b0);
      chk($sformatf("vec%0d tail busy", v), wr_busy, 1'b0);
    end

    // Request during expansion is ignored; next request accepted as soon
    // as wr_busy is sampled low.
    req(11'd640, 8'hA5, 8'h0F, 8'h00, 4'd8);
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) req(11'd0, 8'hFF, 8'h99, 8'h66, 4'd0);
      else wr_en = 1'b0;
      step();
      pix($sformatf("ignore px%0d", i), vecs[0].ea[i], vecs[0].ed[i], vecs[0].mask[7 - i], i < 7);
    end
    req(11'd5, 8'h3C, 8'h00, 8'h00, 4'd0);
    step();
    chk("b2b accept busy", wr_busy, 1'b1);
    chk("b2b idle we", ram_we, 1'b0);
    wr_en = 1'b0;
    step();
    pix("b2b px0", 11'd5, 8'h3C, 1'b1, 1'b0);

    // wr_en held high: direct request re-accepted every other cycle.
    step();
    req(11'd20, 8'h44, 8'h00, 8'h00, 4'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("held we%0d", i), ram_we, (i % 2) == 0);
      chk($sformatf("held busy%0d", i), wr_busy, (i % 2) == 1);
      if ((i % 2) == 0) begin
        chk($sformatf("held addr%0d", i), ram_addr, 11'd20);
        chk($sformatf("held data%0d", i), ram_data, 8'h44);
      end
    end
    wr_en = 1'b0;
    step();
    step();

    // Reset mid-expansion: write enable drops immediately, nothing follows.
    req(11'd200, 8'hFF, 8'h12, 8'h34, 4'd8);
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      pix($sformatf("rst px%0d", i), 11'(200 + i), 8'h12, 1'b1, 1'b1);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("midrst we", ram_we, 1'b0);
    chk("midrst busy", wr_busy, 1'b0);
    step();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("after rst we%0d", i), ram_we, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chroni_pixel_expander.md
Name: chroni_pixel_expander

Overview:
- Write-side front end of the chroni line buffer RAM, in the sys_clk domain.
- Accepts one bitmap byte per request from the chroni font/bitmap fetch FSM, together with on/off colours and a bit count.
- Serialises the request into one colour-indexed pixel write per clock into the line buffer RAM write port, MSB first, at consecutive addresses.
- Also supports single direct-colour pixel writes. Holds wr_busy while expanding.

Parameters:
- ADDR_W, 11, line buffer address width (two 640-pixel halves).
- COLOR_W, 8, pixel colour index width.
- BUF_DEPTH, 1280, number of line buffer entries; addresses wrap from BUF_DEPTH-1 to 0.

Ports:
- sys_clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  request strobe, sampled on the rising sys_clk edge.
- wr_addr  in  ADDR_W  first pixel address of the request.
- wr_data  in  8  bitmap byte, or the direct colour when wr_bitmap_bits=0.
- wr_bitmap_on  in  COLOR_W  colour written for bitmap bits equal to 1.
- wr_bitmap_off  in  COLOR_W  colour written for bitmap bits equal to 0.
- wr_bitmap_bits  in  4  bits to expand: 0 = direct write, 1..8 = bitmap, 9..15 treated as 8.
- wr_busy  out  1  high while a request is in progress; new requests are ignored.
- ram_addr  out  ADDR_W  line buffer RAM write address (registered).
- ram_data  out  COLOR_W  line buffer RAM write data (registered).
- ram_we  out  1  line buffer RAM write enable (registered).

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - wr_busy=0, ram_we=0, ram_addr=0, ram_data=0.
  - Internal shift register and counter are cleared.
- Reset mid-expansion: the remaining bits are dropped and no further ram_we pulses are issued.
- States: IDLE, EXPAND.
- IDLE:
  - ram_we=0.
  - On wr_en=1 at edge N:
    - Latch wr_addr, wr_data, on/off colours.
    - Latch count = (bits==0 ? 1 : min(bits,8)) and mode = direct if bits==0.
    - Set wr_busy=1 and go to EXPAND.
- EXPAND: one pixel is emitted per edge, at edges N+1 .. N+count.
  - Bitmap mode: ram_data = shift[7] ? on : off, then shift left by 1.
  - Direct mode: ram_data = latched wr_data, truncated or zero-extended to COLOR_W.
  - Each emitted pixel sets ram_we=1 and ram_addr = current address; the current address then advances.
  - Address advance: +1, and BUF_DEPTH-1 wraps to 0.
  - Counter decrements each pixel. On the last pixel (edge N+count): wr_busy<=0 and state<=IDLE.
  - ram_we drops to 0 at edge N+count+1 unless a new request has issued a write.
- Latency: first pixel is visible on the RAM port one cycle after acceptance. Throughput is 1 pixel per clock.
- Back-to-back requests: the earliest next accept is edge N+count+1, since wr_busy is sampled low after edge N+count. Its first write is at N+count+2, so there is one idle ram_we cycle between requests.
- wr_en=1 while wr_busy=1: the request is ignored. The latched request, addresses and outputs are unaffected.
- wr_en held high continuously: it is re-accepted each time the block is in IDLE; there is no edge detection.
- Bits 8 with on=off: still 8 writes.
- Address wrap inside a request: e.g. wr_addr=1276 with 8 bits writes 1276..1279 then 0..3.

Optional Feature:
- Macro CHRONI_PIXEL_EXPANDER_TRANSPARENT_EN.
- Defined:
  - In bitmap mode, a 0 bit produces ram_we=0 for that cycle; the address still advances and timing is identical.
  - wr_bitmap_off is unused.
  - Direct mode is unchanged.
- Not defined: every bitmap bit is written; 0 bits use wr_bitmap_off.

Test Plan:
- Reset low, toggle inputs -> wr_busy=0, ram_we=0, ram_addr=0 throughout. Release -> IDLE.
- wr_addr=640, wr_data=0xA5, on=0x0F, off=0x00, bits=8 -> ram_we high 8 consecutive cycles starting 1 cycle after accept.
  - Addresses 640..647, data 0F,00,0F,00,00,0F,00,0F.
  - wr_busy high 8 cycles.
- bits=0, wr_data=0x3C, wr_addr=5 -> single write of 0x3C at addr 5. wr_busy high 1 cycle.
- wr_addr=1278, wr_data=0xFF, bits=4, on=0x11 -> writes 0x11 at 1278, 1279, 0, 1.
- Pulse wr_en at cycle 3 of an 8-bit expansion with different data -> ignored; the original 8 writes complete unchanged.
  - Then a request on the first cycle wr_busy is sampled low is accepted.
  - Assert reset_n low mid-expansion -> ram_we falls immediately and no further writes occur.
- With CHRONI_PIXEL_EXPANDER_TRANSPARENT_EN, data=0xA5, bits=8 -> ram_we pattern 1,0,1,0,0,1,0,1 at addresses advancing 1 per cycle.
